bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_pkg.sv | 19 +
 rtl/arb_rr_pick.sv | 13 +
 rtl/bus_arbiter.sv | 174 +++++++++++++++++
 tb/tb_bus_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared bus definitions: access mode encodings and the arbiter state enum.
package bus_pkg;

    localparam logic [1:0] BUS_NONE  = 2'b00;
    localparam logic [1:0] BUS_READ  = 2'b01;
    localparam logic [1:0] BUS_WRITE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } arb_state_e;

    // Mode 11 is reserved and behaves as no access.
    function automatic logic [1:0] norm_mode(input logic [1:0] mode);
        return (mode == 2'b11) ? BUS_NONE : mode;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Two-requester round-robin choice: on a tie the master that did not own last wins.
module arb_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic last_owner,
    output logic any_req,
    output logic pick
);

    assign any_req = req0 | req1;
    assign pick    = (req0 & req1) ? ~last_owner : req1;

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with hold-limit fairness and a shared tri-state data bus.
// Optional idle-owner watchdog enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int HOLD_MAX     = 8,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic [1:0]  m0_mode,
    input  logic [1:0]  m1_mode,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m1_wdata,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic        m0_rvalid,
    output logic        m1_rvalid,
    output logic [31:0] data_bus_addr,
    output logic [1:0]  data_bus_mode,
    inout  wire  [31:0] data_bus_data,
    output logic        timeout_err
);

    localparam int HOLD_W = $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);

    if (HOLD_MAX < 1 || IDLE_TIMEOUT < 1) begin : g_param_chk
        $error("bus_arbiter: HOLD_MAX and IDLE_TIMEOUT must be at least 1");
    end

    arb_state_e        state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              last_owner;
    logic              pick_vld, pick_m1;
    logic              own_req, other_req;
    logic [31:0]       drv_data;
    logic              timeout_hit;

    arb_rr_pick u_pick (
        .req0       (m0_req),
        .req1       (m1_req),
        .last_owner (last_owner),
        .any_req    (pick_vld),
        .pick       (pick_m1)
    );

    // Owner's request fields are steered onto the bus; the non-owner never reaches it.
    always_comb begin
        data_bus_mode = BUS_NONE;
        data_bus_addr = '0;
        drv_data      = '0;
        own_req       = 1'b0;
        other_req     = 1'b0;
        case (state)
            ST_OWN0: begin
                data_bus_mode = norm_mode(m0_mode);
                data_bus_addr = m0_addr;
                drv_data      = m0_wdata;
                own_req       = m0_req;
                other_req     = m1_req;
            end
            ST_OWN1: begin
                data_bus_mode = norm_mode(m1_mode);
                data_bus_addr = m1_addr;
                drv_data      = m1_wdata;
                own_req       = m1_req;
                other_req     = m0_req;
            end
            default: ;
        endcase
    end

    assign data_bus_data = (data_bus_mode == BUS_WRITE) ? drv_data : 32'bz;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (pick_vld)
                    state_nxt = pick_m1 ? ST_OWN1 : ST_OWN0;
            end
            ST_OWN0: begin
                if (!m0_req || timeout_hit)
                    state_nxt = m1_req ? ST_OWN1 : ST_IDLE;
                else if (m1_req && hold_cnt == HOLD_LIM)
                    state_nxt = ST_OWN1;
            end
            ST_OWN1: begin
                if (!m1_req || timeout_hit)
                    state_nxt = m0_req ? ST_OWN0 : ST_IDLE;
                else if (m0_req && hold_cnt == HOLD_LIM)
                    state_nxt = ST_OWN0;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            hold_cnt   <= '0;
            last_owner <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                hold_cnt <= '0;
            else if (other_req && hold_cnt != HOLD_LIM)
                hold_cnt <= hold_cnt + HOLD_W'(1);
            if (state_nxt == ST_OWN0 && state != ST_OWN0)
                last_owner <= 1'b0;
            else if (state_nxt == ST_OWN1 && state != ST_OWN1)
                last_owner <= 1'b1;
        end
    end

    assign m0_gnt = (state == ST_OWN0);
    assign m1_gnt = (state == ST_OWN1);

    // Read data is sampled at the end of the owning cycle; valid follows one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
        end else begin
            m0_rvalid <= (state == ST_OWN0) && (data_bus_mode == BUS_READ);
            m1_rvalid <= (state == ST_OWN1) && (data_bus_mode == BUS_READ);
            if (state == ST_OWN0 && data_bus_mode == BUS_READ)
                m0_rdata <= data_bus_data;
            if (state == ST_OWN1 && data_bus_mode == BUS_READ)
                m1_rdata <= data_bus_data;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

    logic [IDLE_W-1:0] idle_cnt;
    logic              owner_idle;
    logic              timeout_q;

    assign owner_idle  = (state != ST_IDLE) && own_req && (data_bus_mode == BUS_NONE);
    assign timeout_hit = owner_idle && (idle_cnt == IDLE_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_nxt != state || !owner_idle)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + IDLE_W'(1);
            if (timeout_hit)
                timeout_q <= 1'b1;
        end
    end

    assign timeout_err = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: grants, bus steering, reads, hold limit, reset, watchdog.
module tb_bus_arbiter;
    import bus_pkg::*;

    localparam int HOLD_MAX     = 8;
    localparam int IDLE_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [1:0]  m0_mode = 2'b00, m1_mode = 2'b00;
    logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, timeout_err;
    logic [31:0] m0_rdata, m1_rdata, data_bus_addr;
    logic [1:0]  data_bus_mode;
    wire  [31:0] data_bus_data;
    logic        slave_en = 1'b0;
    logic [31:0] slave_data = '0;

    int n_checks = 0;
    int n_errors = 0;

    assign data_bus_data = slave_en ? slave_data : 32'bz;

    always #5 clk = ~clk;

    bus_arbiter #(.HOLD_MAX(HOLD_MAX), .IDLE_TIMEOUT(IDLE_TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m1_req(m1_req),
        .m0_mode(m0_mode), .m1_mode(m1_mode),
        .m0_addr(m0_addr), .m1_addr(m1_addr),
        .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .data_bus_addr(data_bus_addr), .data_bus_mode(data_bus_mode),
        .data_bus_data(data_bus_data), .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b0;
        #2 reset = 1'b1;
    endtask

    task automatic idle_masters();
        m0_req = 1'b0; m1_req = 1'b0; m0_mode = BUS_NONE; m1_mode = BUS_NONE;
        slave_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        // Reset state
        #3;
        check("rst_gnt", {m1_gnt, m0_gnt}, 0);
        check("rst_rvalid", {m1_rvalid, m0_rvalid}, 0);
        check("rst_rdata0", m0_rdata, 0);
        check("rst_rdata1", m1_rdata, 0);
        check("rst_tmo", timeout_err, 0);
        check("rst_mode", data_bus_mode, BUS_NONE);
        check("rst_addr", data_bus_addr, 0);
        reset = 1'b1;
        step();

        // m0 write
        m0_req = 1'b1; m0_mode = BUS_WRITE; m0_addr = 32'h4030; m0_wdata = 32'h0000_FFFF;
        #1 check("wr_idle_mode", data_bus_mode, BUS_NONE);
        step();
        check("wr_gnt0", m0_gnt, 1);
        check("wr_mode", data_bus_mode, BUS_WRITE);
        check("wr_addr", data_bus_addr, 32'h4030);
        check("wr_data", data_bus_data, 32'h0000_FFFF);
        idle_masters();
        step();
        check("wr_release", m0_gnt, 0);
        check("wr_after_mode", data_bus_mode, BUS_NONE);

        // m1 read
        m1_req = 1'b1; m1_mode = BUS_READ; m1_addr = 32'h4032;
        slave_en = 1'b1; slave_data = 32'h0000_00A5;
        step();
        check("rd_gnt1", m1_gnt, 1);
        check("rd_mode", data_bus_mode, BUS_READ);
        check("rd_addr", data_bus_addr, 32'h4032);
        check("rd_rvalid_early", m1_rvalid, 0);
        step();
        check("rd_rvalid", m1_rvalid, 1);
        check("rd_rdata", m1_rdata, 32'h0000_00A5);
        idle_masters();
        step();
        check("rd_rvalid_off", m1_rvalid, 0);
        check("rd_rdata_hold", m1_rdata, 32'h0000_00A5);
        step();

        // Simultaneous requests after reset, direct handover
        pulse_reset();
        m0_req = 1'b1; m0_mode = BUS_WRITE; m0_addr = 32'h100; m0_wdata = 32'h1;
        m1_req = 1'b1; m1_mode = BUS_READ;  m1_addr = 32'h200;
        step();
        check("tie_gnt", {m1_gnt, m0_gnt}, 2'b01);
        check("tie_addr", data_bus_addr, 32'h100);
        m0_req = 1'b0; m0_mode = BUS_NONE;
        step();
        check("handover_gnt", {m1_gnt, m0_gnt}, 2'b10);
        check("handover_addr", data_bus_addr, 32'h200);
        check("handover_mode", data_bus_mode, BUS_READ);
        idle_masters();
        step();

        // Hold limit: m0 keeps reading while m1 waits
        pulse_reset();
        m0_req = 1'b1; m0_mode = BUS_READ; m0_addr = 32'h10;
        slave_en = 1'b1; slave_data = 32'h11;
        step();
        m1_req = 1'b1; m1_mode = BUS_WRITE; m1_addr = 32'h20; m1_wdata = 32'h22;
        for (int i = 0; i <= HOLD_MAX; i++) begin
            #1;
            check($sformatf("hold_cyc%0d", i), {m1_gnt, m0_gnt, data_bus_addr[7:0]}, {2'b01, 8'h10});
            step();
        end
        slave_en = 1'b0;
        #1;
        check("hold_gnt1", {m1_gnt, m0_gnt}, 2'b10);
        check("hold_mode1", data_bus_mode, BUS_WRITE);
        check("hold_data1", data_bus_data, 32'h22);
        check("hold_last_rd", {m0_rvalid, m0_rdata}, {1'b1, 32'h11});
        idle_masters();
        step();
        check("hold_rvalid_off", m0_rvalid, 0);
        step();

        // Reset pulsed during an m0 read
        m0_req = 1'b1; m0_mode = BUS_READ; m0_addr = 32'h30;
        slave_en = 1'b1; slave_data = 32'h77;
        step();
        check("rr_mode_before", data_bus_mode, BUS_READ);
        #2 reset = 1'b0;
        #1;
        check("rr_mode_async", data_bus_mode, BUS_NONE);
        check("rr_gnt_async", m0_gnt, 0);
        idle_masters();
        #1 reset = 1'b1;
        step();
        check("rr_no_rvalid", m0_rvalid, 0);
        check("rr_rdata", m0_rdata, 0);
        check("rr_idle_gnt", {m1_gnt, m0_gnt}, 0);

        // Idle owner watchdog
        m0_req = 1'b1; m0_mode = BUS_NONE;
        step();
        check("wd_gnt", m0_gnt, 1);
        repeat (IDLE_TIMEOUT) step();
`ifdef BUS_ARB_TIMEOUT_EN
        check("wd_revoked", m0_gnt, 0);
        check("wd_err", timeout_err, 1);
        step();
        check("wd_err_sticky", timeout_err, 1);
`else
        check("wd_kept", m0_gnt, 1);
        check("wd_err", timeout_err, 0);
        step();
        check("wd_kept2", m0_gnt, 1);
`endif
        idle_masters();
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
